// File: rtl/depuncturer.sv
// Depuncturer: rebuilds (A,B) code-bit pairs with erasure flags from a punctured serial stream.
// Optional status outputs (Pair_cnt, Rate_err) are enabled by defining DEPUNCT_STATUS_EN.
module depuncturer #(
  parameter int   CNT_W     = 16,
  parameter logic ERASE_BIT = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             EN,
  input  logic             Start,
  input  logic [1:0]       Rate,
  input  logic             In_valid,
  input  logic             In_data,
  output logic             Out_valid,
  output logic             Out_a,
  output logic             Out_b,
  output logic             Erase_a,
  output logic             Erase_b,
  output logic [CNT_W-1:0] Pair_cnt,
  output logic             Rate_err
);

  logic [1:0] rate_p0, phase_p0;
  logic       hold_a_p0;

  logic [1:0] rate_eff, phase_eff, last_ph;
  logic       hold_eff;
  logic [1:0] rate_nxt, phase_nxt;
  logic       hold_nxt;
  logic       emit_p0, a_p0, b_p0, ea_p0, eb_p0;

  // Stage p0: Start overrides the stored pattern state within the same cycle
  always_comb begin
    rate_eff  = Start ? Rate : rate_p0;
    phase_eff = Start ? 2'd0 : phase_p0;
    hold_eff  = Start ? 1'b0 : hold_a_p0;
    case (rate_eff)
      2'b01:   last_ph = 2'd2;
      2'b10:   last_ph = 2'd3;
      default: last_ph = 2'd1;
    endcase

    rate_nxt  = rate_p0;
    phase_nxt = phase_p0;
    hold_nxt  = hold_a_p0;
    emit_p0   = 1'b0;
    a_p0      = Out_a;
    b_p0      = Out_b;
    ea_p0     = Erase_a;
    eb_p0     = Erase_b;

    if (EN) begin
      rate_nxt  = rate_eff;
      phase_nxt = phase_eff;
      hold_nxt  = hold_eff;
      if (In_valid) begin
        phase_nxt = (phase_eff == last_ph) ? 2'd0 : phase_eff + 2'd1;
        case (phase_eff)
          2'd0: hold_nxt = In_data;
          2'd1: begin
            emit_p0 = 1'b1;
            a_p0    = hold_eff;
            b_p0    = In_data;
            ea_p0   = 1'b0;
            eb_p0   = 1'b0;
          end
          2'd2: begin
            emit_p0 = 1'b1;
            a_p0    = In_data;
            b_p0    = ERASE_BIT;
            ea_p0   = 1'b0;
            eb_p0   = 1'b1;
          end
          default: begin
            emit_p0 = 1'b1;
            a_p0    = ERASE_BIT;
            b_p0    = In_data;
            ea_p0   = 1'b1;
            eb_p0   = 1'b0;
          end
        endcase
      end
    end
  end

  // Stage p1: registered pattern state and output pair
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rate_p0   <= 2'b00;
      phase_p0  <= 2'd0;
      hold_a_p0 <= 1'b0;
      Out_valid <= 1'b0;
      Out_a     <= 1'b0;
      Out_b     <= 1'b0;
      Erase_a   <= 1'b0;
      Erase_b   <= 1'b0;
    end else begin
      rate_p0   <= rate_nxt;
      phase_p0  <= phase_nxt;
      hold_a_p0 <= hold_nxt;
      Out_valid <= emit_p0;
      if (emit_p0) begin
        Out_a   <= a_p0;
        Out_b   <= b_p0;
        Erase_a <= ea_p0;
        Erase_b <= eb_p0;
      end
    end
  end

`ifdef DEPUNCT_STATUS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Pair_cnt <= '0;
      Rate_err <= 1'b0;
    end else if (EN && Start) begin
      Pair_cnt <= {{(CNT_W-1){1'b0}}, emit_p0};
      Rate_err <= (Rate == 2'b11);
    end else if (emit_p0) begin
      Pair_cnt <= sat_inc(Pair_cnt);
    end
  end
`else
  assign Pair_cnt = '0;
  assign Rate_err = 1'b0;
`endif

endmodule

// File: tb/tb_depuncturer.sv
// Testbench for depuncturer: puncture-mask reference model plus directed literal checks.
module tb_depuncturer;
  localparam int   CNT_W = 16;
  localparam logic ERASE = 1'b0;
`ifdef DEPUNCT_STATUS_EN
  localparam int STATUS = 1;
`else
  localparam int STATUS = 0;
`endif

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             EN = 1'b0;
  logic             Start = 1'b0;
  logic [1:0]       Rate = 2'b00;
  logic             In_valid = 1'b0;
  logic             In_data = 1'b0;
  logic             Out_valid, Out_a, Out_b, Erase_a, Erase_b, Rate_err;
  logic [CNT_W-1:0] Pair_cnt;

  int checks = 0;
  int errors = 0;

  depuncturer #(.CNT_W(CNT_W), .ERASE_BIT(ERASE)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .EN(EN), .Start(Start), .Rate(Rate),
    .In_valid(In_valid), .In_data(In_data), .Out_valid(Out_valid),
    .Out_a(Out_a), .Out_b(Out_b), .Erase_a(Erase_a), .Erase_b(Erase_b),
    .Pair_cnt(Pair_cnt), .Rate_err(Rate_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Mother-code stream A1 B1 A2 B2 A3 B3 -> slots 0..5; mask marks transmitted slots
  function automatic logic kept(input int r, input int s);
    logic [5:0] m;
    m = (r == 1) ? 6'b000111 : (r == 2) ? 6'b100111 : 6'b000011;
    return (s >= 0 && s < 6) ? m[s] : 1'b0;
  endfunction

  function automatic int n_kept(input int r);
    return (r == 1) ? 3 : (r == 2) ? 4 : 2;
  endfunction

  function automatic int slot_of(input int r, input int k);
    int c = 0;
    for (int s = 0; s < 6; s++) begin
      if (kept(r, s)) begin
        if (c == k) return s;
        c++;
      end
    end
    return 0;
  endfunction

  int         m_rate, m_k, m_s, m_j;
  logic [5:0] slot_val;
  logic       e_vld, e_a, e_b, e_ea, e_eb, m_rerr;
  int         m_cnt;

  initial begin
    m_rate = 0; m_k = 0; slot_val = '0; m_cnt = 0; m_rerr = 1'b0;
    e_vld = 1'b0; e_a = 1'b0; e_b = 1'b0; e_ea = 1'b0; e_eb = 1'b0;
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        m_rate = 0; m_k = 0; m_cnt = 0; m_rerr = 1'b0;
        e_vld = 1'b0; e_a = 1'b0; e_b = 1'b0; e_ea = 1'b0; e_eb = 1'b0;
      end else begin
        e_vld = 1'b0;
        if (EN) begin
          if (Start) begin
            m_rate = int'(Rate); m_k = 0; m_cnt = 0; m_rerr = (Rate == 2'b11);
          end
          if (In_valid) begin
            m_s = slot_of(m_rate, m_k);
            slot_val[m_s] = In_data;
            // A pair is complete once its last transmitted slot arrives
            if ((m_s % 2 == 1) || !kept(m_rate, m_s + 1)) begin
              m_j   = m_s - (m_s % 2);
              e_vld = 1'b1;
              e_ea  = !kept(m_rate, m_j);
              e_eb  = !kept(m_rate, m_j + 1);
              e_a   = e_ea ? ERASE : slot_val[m_j];
              e_b   = e_eb ? ERASE : slot_val[m_j + 1];
              if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
            m_k++;
            if (m_k == n_kept(m_rate)) m_k = 0;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge Clk);
      check("m_valid", Out_valid, e_vld);
      check("m_a", Out_a, e_a);
      check("m_b", Out_b, e_b);
      check("m_ea", Erase_a, e_ea);
      check("m_eb", Erase_b, e_eb);
      check("m_cnt", Pair_cnt, STATUS ? m_cnt : 0);
      check("m_rerr", Rate_err, STATUS ? m_rerr : 1'b0);
    end
  end

  task automatic start_pulse(input logic [1:0] r);
    @(posedge Clk); #1;
    EN = 1'b1; Start = 1'b1; Rate = r; In_valid = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic drive_bit(input logic st, input logic [1:0] r, input logic d, input logic v,
                           input logic a, input logic b, input logic [1:0] e, input string nm);
    @(posedge Clk); #1;
    EN = 1'b1; Start = st; Rate = r; In_valid = 1'b1; In_data = d;
    @(posedge Clk); #1;
    Start = 1'b0; In_valid = 1'b0;
    check({nm, "_vld"}, Out_valid, v);
    if (v) begin
      check({nm, "_a"}, Out_a, a);
      check({nm, "_b"}, Out_b, b);
      check({nm, "_e"}, {Erase_a, Erase_b}, e);
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check("rst_vld", Out_valid, 1'b0);
    check("rst_ab", {Out_a, Out_b, Erase_a, Erase_b}, 4'b0000);
    check("rst_status", {Rate_err, Pair_cnt}, '0);
    Reset_n = 1'b1;

    // Rate 1/2; Rate changes between Starts must be ignored
    start_pulse(2'b00);
    drive_bit(0, 2'b10, 1, 0, 0, 0, 2'b00, "r12_1");
    drive_bit(0, 2'b01, 0, 1, 1, 0, 2'b00, "r12_2");
    drive_bit(0, 2'b11, 0, 0, 0, 0, 2'b00, "r12_3");
    drive_bit(0, 2'b10, 1, 1, 0, 1, 2'b00, "r12_4");

    // Rate 3/4 twice to cover wrap
    start_pulse(2'b10);
    for (int g = 0; g < 2; g++) begin
      drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "r34_1");
      drive_bit(0, 2'b00, 0, 1, 1, 0, 2'b00, "r34_2");
      drive_bit(0, 2'b00, 1, 1, 1, ERASE, 2'b01, "r34_3");
      drive_bit(0, 2'b00, 1, 1, ERASE, 1, 2'b10, "r34_4");
    end

    // Rate 2/3
    start_pulse(2'b01);
    drive_bit(0, 2'b00, 0, 0, 0, 0, 2'b00, "r23_1");
    drive_bit(0, 2'b00, 1, 1, 0, 1, 2'b00, "r23_2");
    drive_bit(0, 2'b00, 1, 1, 1, ERASE, 2'b01, "r23_3");
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "r23_4");
    drive_bit(0, 2'b00, 0, 1, 1, 0, 2'b00, "r23_5");
    drive_bit(0, 2'b00, 0, 1, 0, ERASE, 2'b01, "r23_6");

    // EN low stall at 3/4; Start and bits offered while disabled are ignored
    start_pulse(2'b10);
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "stl_1");
    drive_bit(0, 2'b00, 0, 1, 1, 0, 2'b00, "stl_2");
    @(posedge Clk); #1;
    EN = 1'b0; Start = 1'b1; Rate = 2'b00; In_valid = 1'b1; In_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      check("stl_idle", Out_valid, 1'b0);
      check("stl_hold", {Out_a, Out_b, Erase_a, Erase_b}, 4'b1000);
    end
    EN = 1'b1; Start = 1'b0; In_valid = 1'b0;
    drive_bit(0, 2'b00, 1, 1, 1, ERASE, 2'b01, "stl_3");
    drive_bit(0, 2'b00, 1, 1, ERASE, 1, 2'b10, "stl_4");

    // Restart after one bit drops the held A
    start_pulse(2'b00);
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "rs_1");
    start_pulse(2'b00);
    drive_bit(0, 2'b00, 0, 0, 0, 0, 2'b00, "rs_2");
    drive_bit(0, 2'b00, 1, 1, 0, 1, 2'b00, "rs_3");

    // Start with a bit in the same cycle: bit is phase 0 under the new rate
    drive_bit(1, 2'b10, 1, 0, 0, 0, 2'b00, "sb_1");
    drive_bit(0, 2'b00, 0, 1, 1, 0, 2'b00, "sb_2");
    drive_bit(0, 2'b00, 0, 1, 0, ERASE, 2'b01, "sb_3");

    // Status: 12 bits at 3/4 make 9 pairs
    start_pulse(2'b10);
    for (int i = 0; i < 12; i++) begin
      @(posedge Clk); #1;
      In_valid = 1'b1; In_data = 1'($urandom_range(0, 1));
    end
    @(posedge Clk); #1;
    In_valid = 1'b0;
    check("cnt_12", Pair_cnt, STATUS ? 9 : 0);
    start_pulse(2'b11);
    check("rerr_set", Rate_err, STATUS ? 1 : 0);
    check("cnt_clr11", Pair_cnt, 0);
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "r11_1");
    drive_bit(0, 2'b00, 1, 1, 1, 1, 2'b00, "r11_2");
    check("cnt_r11", Pair_cnt, STATUS ? 1 : 0);
    start_pulse(2'b00);
    check("rerr_clr", Rate_err, 1'b0);
    check("cnt_clr", Pair_cnt, 0);

    // Async reset mid-pattern right after a pair with nonzero data
    start_pulse(2'b10);
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "ar_1");
    drive_bit(0, 2'b00, 1, 1, 1, 1, 2'b00, "ar_2");
    drive_bit(0, 2'b00, 1, 1, 1, ERASE, 2'b01, "ar_3");
    #2 Reset_n = 1'b0;
    #1;
    check("ar_vld", Out_valid, 1'b0);
    check("ar_out", {Out_a, Out_b, Erase_a, Erase_b}, 4'b0000);
    check("ar_status", {Rate_err, Pair_cnt}, '0);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    drive_bit(0, 2'b00, 1, 0, 0, 0, 2'b00, "ar_4");
    drive_bit(0, 2'b00, 0, 1, 1, 0, 2'b00, "ar_5");

    repeat (2) @(posedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "timeout");
  end
endmodule
